// File: rtl/acl_cfg_sequencer.sv
// acl_cfg_sequencer
//   Host-side configuration sequencer for the per-port RX ACL match table.
//   Stages up to 64 match bytes written by the host, then on a WRITE, COMMIT
//   or CLEAR command drives the ACL programming port cycle by cycle, gated by
//   the table's ready flag. All outputs are registered.
//
// Optional feature macro: ACL_CFG_TIMEOUT_EN
//   Defined: a ready-wait timeout of RDY_TIMEOUT cycles reports err=3.
//   Undefined: the sequencer waits for ready indefinitely.
//
// Ports
//   i_clk, i_rst               clock, asynchronous active-low reset
//   i_host_buf_*               staging buffer byte writes (accepted only when idle)
//   i_host_cmd_* / o_host_cmd_rdy  command handshake and arguments
//   o_host_done, o_host_err    one-cycle completion pulse with status
//   o_acl_*, i_acl_list_rdy_regs   ACL table programming port
module acl_cfg_sequencer #(
  parameter int PORT_NUM    = 4,
  parameter int RDY_TIMEOUT = 1024
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_host_buf_we,
  input  logic [5:0]          i_host_buf_waddr,
  input  logic [7:0]          i_host_buf_din,
  input  logic                i_host_cmd_vld,
  output logic                o_host_cmd_rdy,
  input  logic [1:0]          i_host_cmd_op,
  input  logic [PORT_NUM-1:0] i_host_port_sel,
  input  logic [4:0]          i_host_item_sel,
  input  logic [6:0]          i_host_item_len,
  input  logic [15:0]         i_host_item_rslt,
  output logic                o_host_done,
  output logic [1:0]          o_host_err,
  output logic [PORT_NUM-1:0] o_acl_port_sel,
  output logic                o_acl_clr_list_regs,
  input  logic                i_acl_list_rdy_regs,
  output logic [4:0]          o_acl_item_sel_regs,
  output logic [5:0]          o_acl_item_waddr_regs,
  output logic [7:0]          o_acl_item_din_regs,
  output logic                o_acl_item_we_regs,
  output logic [15:0]         o_acl_item_rslt_regs,
  output logic                o_acl_item_complete_regs
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_WRITE    = 3'd2,
    S_COMMIT   = 3'd3,
    S_CLEAR    = 3'd4,
    S_CLR_WAIT = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_COMMIT = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_ARG = 2'd1;
  localparam logic [1:0] ERR_OP  = 2'd2;
`ifdef ACL_CFG_TIMEOUT_EN
  localparam logic [1:0] ERR_TMO = 2'd3;
  localparam int TMO_W = (RDY_TIMEOUT > 2) ? $clog2(RDY_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RDY_TIMEOUT - 1);
`endif

  // Status a command would produce if rejected at accept (ERR_OK = accepted).
  function automatic logic [1:0] arg_check(input logic [1:0]          op,
                                           input logic [PORT_NUM-1:0] port,
                                           input logic [6:0]          len);
    logic [1:0] err;
    err = ERR_OK;
    case (op)
      OP_WRITE: begin
        if (port == {PORT_NUM{1'b0}} || len == 7'd0 || len > 7'd64) err = ERR_ARG;
        else                                                          err = ERR_OK;
      end
      OP_COMMIT, OP_CLEAR: begin
        if (port == {PORT_NUM{1'b0}}) err = ERR_ARG;
        else                          err = ERR_OK;
      end
      default: err = ERR_OP;
    endcase
    return err;
  endfunction

  state_t      state_q;
  logic [1:0]  op_q;
  logic [5:0]  len_m1_q;   // last byte address of the current WRITE
  logic [1:0]  ign_q;      // rdy-ignore cycles spent in CLR_WAIT
  logic [7:0]  stage_q [64];
`ifdef ACL_CFG_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q;
`endif

  logic                cmd_rdy_q, done_q, clr_q, we_q, complete_q;
  logic [1:0]          err_q;
  logic [PORT_NUM-1:0] port_sel_q;
  logic [4:0]          item_q;
  logic [5:0]          waddr_q;
  logic [7:0]          din_q;
  logic [15:0]         rslt_q;

  logic       accept_s;
  logic [1:0] arg_err_s;

  assign accept_s  = i_host_cmd_vld & cmd_rdy_q;
  assign arg_err_s = arg_check(i_host_cmd_op, i_host_port_sel, i_host_item_len);

  // Staging buffer: host byte writes land only while the sequencer is idle.
  always_ff @(posedge i_clk) begin
    if (i_host_buf_we && cmd_rdy_q) stage_q[i_host_buf_waddr] <= i_host_buf_din;
  end

  // Command FSM; strobes are set on the edge that enters their state so that
  // every output is a flop.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      op_q       <= 2'd0;
      len_m1_q   <= 6'd0;
      ign_q      <= 2'd0;
`ifdef ACL_CFG_TIMEOUT_EN
      tmo_q      <= {TMO_W{1'b0}};
`endif
      cmd_rdy_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 2'd0;
      clr_q      <= 1'b0;
      we_q       <= 1'b0;
      complete_q <= 1'b0;
      port_sel_q <= {PORT_NUM{1'b0}};
      item_q     <= 5'd0;
      waddr_q    <= 6'd0;
      din_q      <= 8'd0;
      rslt_q     <= 16'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_rdy_q <= 1'b1;
          if (accept_s) begin
            cmd_rdy_q  <= 1'b0;
            op_q       <= i_host_cmd_op;
            len_m1_q   <= 6'(i_host_item_len - 7'd1);
            port_sel_q <= i_host_port_sel;
            item_q     <= i_host_item_sel;
            rslt_q     <= i_host_item_rslt;
`ifdef ACL_CFG_TIMEOUT_EN
            tmo_q      <= {TMO_W{1'b0}};
`endif
            if (arg_err_s != ERR_OK) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= arg_err_s;
            end else begin
              state_q <= S_WAIT_RDY;
            end
          end
        end
        S_WAIT_RDY: begin
          if (i_acl_list_rdy_regs) begin
            case (op_q)
              OP_WRITE: begin
                state_q <= S_WRITE;
                we_q    <= 1'b1;
                waddr_q <= 6'd0;
                din_q   <= stage_q[0];
              end
              OP_COMMIT: begin
                state_q    <= S_COMMIT;
                complete_q <= 1'b1;
              end
              OP_CLEAR: begin
                state_q <= S_CLEAR;
                clr_q   <= 1'b1;
              end
              default: begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                err_q   <= ERR_OP;
              end
            endcase
          end
`ifdef ACL_CFG_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= ERR_TMO;
          end else begin
            tmo_q <= tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
          end
`endif
        end
        S_WRITE: begin
          // The byte stream never pauses; rdy is not looked at here.
          if (waddr_q == len_m1_q) begin
            state_q <= S_DONE;
            we_q    <= 1'b0;
            waddr_q <= 6'd0;
            din_q   <= 8'd0;
            done_q  <= 1'b1;
            err_q   <= ERR_OK;
          end else begin
            waddr_q <= waddr_q + 6'd1;
            din_q   <= stage_q[waddr_q + 6'd1];
          end
        end
        S_COMMIT: begin
          state_q    <= S_DONE;
          complete_q <= 1'b0;
          done_q     <= 1'b1;
          err_q      <= ERR_OK;
        end
        S_CLEAR: begin
          state_q <= S_CLR_WAIT;
          clr_q   <= 1'b0;
          ign_q   <= 2'd0;
`ifdef ACL_CFG_TIMEOUT_EN
          tmo_q   <= {TMO_W{1'b0}};
`endif
        end
        S_CLR_WAIT: begin
          // The table may still show the stale idle flag right after clr.
          if (ign_q == 2'd2 && i_acl_list_rdy_regs) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= ERR_OK;
          end
`ifdef ACL_CFG_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= ERR_TMO;
          end else begin
            tmo_q <= tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
          end
`endif
          if (ign_q != 2'd2) ign_q <= ign_q + 2'd1;
        end
        S_DONE: begin
          state_q    <= S_IDLE;
          done_q     <= 1'b0;
          err_q      <= 2'd0;
          cmd_rdy_q  <= 1'b1;
          port_sel_q <= {PORT_NUM{1'b0}};
          item_q     <= 5'd0;
          rslt_q     <= 16'd0;
        end
        default: begin
          state_q    <= S_IDLE;
          done_q     <= 1'b0;
          clr_q      <= 1'b0;
          we_q       <= 1'b0;
          complete_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_host_cmd_rdy           = cmd_rdy_q;
  assign o_host_done              = done_q;
  assign o_host_err               = err_q;
  assign o_acl_port_sel           = port_sel_q;
  assign o_acl_clr_list_regs      = clr_q;
  assign o_acl_item_sel_regs      = item_q;
  assign o_acl_item_waddr_regs    = waddr_q;
  assign o_acl_item_din_regs      = din_q;
  assign o_acl_item_we_regs       = we_q;
  assign o_acl_item_rslt_regs     = rslt_q;
  assign o_acl_item_complete_regs = complete_q;

endmodule

// File: tb/tb_acl_cfg_sequencer.sv
// Scoreboard bench for acl_cfg_sequencer: the driver pushes the expected
// ACL strobes and done pulses into a queue, the monitor pops and compares
// them whenever the DUT presents one.
module tb_acl_cfg_sequencer;
  localparam int PN = 4;
  localparam int K_WE = 1, K_CMP = 2, K_CLR = 3, K_DONE = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          buf_we;
  logic [5:0]    buf_waddr;
  logic [7:0]    buf_din;
  logic          cmd_vld;
  logic          cmd_rdy;
  logic [1:0]    cmd_op;
  logic [PN-1:0] port_sel;
  logic [4:0]    item_sel;
  logic [6:0]    item_len;
  logic [15:0]   item_rslt;
  logic          host_done;
  logic [1:0]    host_err;
  logic [PN-1:0] acl_port;
  logic          acl_clr;
  logic          acl_rdy;
  logic [4:0]    acl_item;
  logic [5:0]    acl_waddr;
  logic [7:0]    acl_din;
  logic          acl_we;
  logic [15:0]   acl_rslt;
  logic          acl_cmp;

  acl_cfg_sequencer #(.PORT_NUM(PN), .RDY_TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_host_buf_we(buf_we), .i_host_buf_waddr(buf_waddr), .i_host_buf_din(buf_din),
    .i_host_cmd_vld(cmd_vld), .o_host_cmd_rdy(cmd_rdy), .i_host_cmd_op(cmd_op),
    .i_host_port_sel(port_sel), .i_host_item_sel(item_sel), .i_host_item_len(item_len),
    .i_host_item_rslt(item_rslt), .o_host_done(host_done), .o_host_err(host_err),
    .o_acl_port_sel(acl_port), .o_acl_clr_list_regs(acl_clr), .i_acl_list_rdy_regs(acl_rdy),
    .o_acl_item_sel_regs(acl_item), .o_acl_item_waddr_regs(acl_waddr),
    .o_acl_item_din_regs(acl_din), .o_acl_item_we_regs(acl_we),
    .o_acl_item_rslt_regs(acl_rslt), .o_acl_item_complete_regs(acl_cmp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          cyc;   // -1: cycle not checked
    logic [63:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] exp_buf [64];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  bit         mon_en = 1'b0;
  logic [45:0] all_out;

  assign all_out = {cmd_rdy, host_done, host_err, acl_port, acl_clr, acl_item,
                    acl_waddr, acl_din, acl_we, acl_rslt, acl_cmp};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] we_pack(input logic [3:0] p, input logic [4:0] it,
                                          input logic [15:0] r, input logic [5:0] a,
                                          input logic [7:0] d);
    return {25'd0, p, it, r, a, d};
  endfunction

  function automatic logic [63:0] ctl_pack(input logic [3:0] p, input logic [4:0] it,
                                           input logic [15:0] r);
    return {39'd0, p, it, r};
  endfunction

  task automatic push(input int kind, input int c, input logic [63:0] data);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [63:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d data %0h at cycle %0d want none", kind, data, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 64'(kind), 64'(e.kind));
      if (e.cyc >= 0) check("event_cycle", 64'(cyc), 64'(e.cyc));
      check("event_data", data, e.data);
    end
  endtask

  // Monitor: compares every strobe and done pulse against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (acl_we)  observe(K_WE, we_pack(acl_port, acl_item, acl_rslt, acl_waddr, acl_din));
      if (acl_cmp) observe(K_CMP, ctl_pack(acl_port, acl_item, acl_rslt));
      if (acl_clr) observe(K_CLR, ctl_pack(acl_port, acl_item, acl_rslt));
      if (host_done) begin
        done_cnt++;
        observe(K_DONE, {62'd0, host_err});
      end
    end
  end

  task automatic load_byte(input int a, input logic [7:0] d);
    @(negedge clk);
    buf_we = 1'b1;
    buf_waddr = 6'(a);
    buf_din = d;
    exp_buf[a] = d;
    @(posedge clk);
    #1 buf_we = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] p, input logic [4:0] it,
                       input logic [6:0] len, input logic [15:0] r, output int e0);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("cmd_rdy_timeout", 64'(cmd_rdy), 64'd1);
    cmd_vld = 1'b1; cmd_op = op; port_sel = p; item_sel = it; item_len = len; item_rslt = r;
    @(posedge clk);
    #1;
    e0 = cyc;
    cmd_vld = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !cmd_rdy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int d0;
    logic [1:0] rj_op  [4] = '{2'b00, 2'b00, 2'b11, 2'b01};
    logic [3:0] rj_prt [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
    logic [6:0] rj_len [4] = '{7'd0, 7'd65, 7'd4, 7'd1};
    logic [1:0] rj_err [4] = '{2'd1, 2'd1, 2'd2, 2'd1};

    buf_we = 1'b0; buf_waddr = 6'd0; buf_din = 8'd0; cmd_vld = 1'b0; cmd_op = 2'd0;
    port_sel = 4'd0; item_sel = 5'd0; item_len = 7'd0; item_rslt = 16'd0; acl_rdy = 1'b1;

    repeat (3) @(posedge clk);
    #1 check("reset_outputs", 64'(all_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rdy_before_first_edge", 64'(cmd_rdy), 64'd0);
    @(posedge clk);
    #1 check("rdy_after_release", 64'(cmd_rdy), 64'd1);
    mon_en = 1'b1;

    // WRITE of 4 bytes A0..A3
    for (int i = 0; i < 4; i++) load_byte(i, 8'(8'hA0 + i));
    issue(2'b00, 4'b0001, 5'd5, 7'd4, 16'h0203, e0);
    for (int i = 0; i < 4; i++) push(K_WE, e0 + 1 + i, we_pack(4'b0001, 5'd5, 16'h0203, 6'(i), exp_buf[i]));
    push(K_DONE, e0 + 5, 64'd0);
    wait_idle(100);

    // WRITE of 64 bytes, then COMMIT
    for (int i = 0; i < 64; i++) load_byte(i, 8'(i * 3 + 7));
    issue(2'b00, 4'b0010, 5'd31, 7'd64, 16'hBEEF, e0);
    for (int i = 0; i < 64; i++) push(K_WE, e0 + 1 + i, we_pack(4'b0010, 5'd31, 16'hBEEF, 6'(i), exp_buf[i]));
    push(K_DONE, e0 + 65, 64'd0);
    wait_idle(200);
    issue(2'b01, 4'b0010, 5'd31, 7'd0, 16'hBEEF, e0);
    push(K_CMP, e0 + 1, ctl_pack(4'b0010, 5'd31, 16'hBEEF));
    push(K_DONE, e0 + 2, 64'd0);
    wait_idle(100);

    // CLEAR with rdy low for 10 cycles after the clr pulse
    d0 = done_cnt;
    issue(2'b10, 4'b1000, 5'd3, 7'd0, 16'h0000, e0);
    push(K_CLR, e0 + 1, ctl_pack(4'b1000, 5'd3, 16'h0000));
    push(K_DONE, -1, 64'd0);
    @(posedge clk);
    #1 acl_rdy = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("clear_no_early_done", 64'(done_cnt), 64'(d0));
    acl_rdy = 1'b1;
    wait_idle(100);

    // Rejected commands: done the cycle after accept, rdy back one cycle later
    for (int k = 0; k < 4; k++) begin
      issue(rj_op[k], rj_prt[k], 5'd1, rj_len[k], 16'h1234, e0);
      push(K_DONE, e0, {62'd0, rj_err[k]});
      @(negedge clk);
      check("reject_rdy_low", 64'(cmd_rdy), 64'd0);
      @(posedge clk);
      #1 check("reject_rdy_back", 64'(cmd_rdy), 64'd1);
      wait_idle(50);
    end

    // rdy held low in WAIT_RDY
    acl_rdy = 1'b0;
    d0 = done_cnt;
    issue(2'b01, 4'b0001, 5'd2, 7'd0, 16'h1111, e0);
`ifdef ACL_CFG_TIMEOUT_EN
    push(K_DONE, e0 + 16, 64'd3);
    wait_idle(100);
    acl_rdy = 1'b1;
`else
    repeat (1000) @(posedge clk);
    #1 check("no_done_while_rdy_low", 64'(done_cnt), 64'(d0));
    push(K_CMP, -1, ctl_pack(4'b0001, 5'd2, 16'h1111));
    push(K_DONE, -1, 64'd0);
    acl_rdy = 1'b1;
    wait_idle(100);
`endif

    // Reset in the middle of a 32-byte WRITE
    issue(2'b00, 4'b0001, 5'd7, 7'd32, 16'h5555, e0);
    for (int i = 0; i < 32; i++) push(K_WE, e0 + 1 + i, we_pack(4'b0001, 5'd7, 16'h5555, 6'(i), exp_buf[i]));
    push(K_DONE, e0 + 33, 64'd0);
    repeat (10) @(posedge clk);
    #1 check("we_before_reset", 64'(acl_we), 64'd1);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1 check("reset_mid_write_outputs", 64'(all_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rdy_low_at_release", 64'(cmd_rdy), 64'd0);
    @(posedge clk);
    #1 check("rdy_after_mid_reset", 64'(cmd_rdy), 64'd1);

    // Single-byte WRITE after reset
    load_byte(0, 8'h3C);
    issue(2'b00, 4'b0100, 5'd9, 7'd1, 16'h0A0B, e0);
    push(K_WE, e0 + 1, we_pack(4'b0100, 5'd9, 16'h0A0B, 6'd0, 8'h3C));
    push(K_DONE, e0 + 2, 64'd0);
    wait_idle(50);

    repeat (3) @(posedge clk);
    #1 check("queue_empty_at_end", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/acl_cfg_sequencer.md
# acl_cfg_sequencer

Host-side configuration sequencer for the per-port RX ACL match table. It accepts item-write, commit and clear commands from the register block and stages up to 64 match bytes in a local buffer. It then drives the ACL programming port (port select, byte writes, result, complete, clear) cycle by cycle, gated by the table's ready flag. It sits between the CSR decoder and the RX frame ACL manager of each switch instance.

## Interface
- PORT_NUM, 4, number of switch ports (width of the port-select mask)
- RDY_TIMEOUT, 1024, cycles to wait for ACL ready before aborting (used only with the timeout feature)

- i_clk  in  1  core clock, 250 MHz
- i_rst  in  1  asynchronous, active-low reset
- i_host_buf_we  in  1  staging buffer byte write strobe
- i_host_buf_waddr  in  6  staging buffer byte address
- i_host_buf_din  in  8  staging buffer byte data
- i_host_cmd_vld  in  1  command valid
- o_host_cmd_rdy  out  1  command ready; high only in IDLE
- i_host_cmd_op  in  2  command opcode: 00 WRITE, 01 COMMIT, 10 CLEAR, 11 reserved
- i_host_port_sel  in  PORT_NUM  target port mask
- i_host_item_sel  in  5  item index (0–31)
- i_host_item_len  in  7  match length in bytes, valid range 1–64
- i_host_item_rslt  in  16  result: [7:0] frame type, [15:8] forward port
- o_host_done  out  1  one-cycle completion pulse
- o_host_err  out  2  status, valid with done: 0 ok, 1 bad argument, 2 bad opcode, 3 timeout
- o_acl_port_sel  out  PORT_NUM  to the ACL port-select input
- o_acl_clr_list_regs  out  1  list clear pulse
- i_acl_list_rdy_regs  in  1  ACL table idle
- o_acl_item_sel_regs  out  5  item select
- o_acl_item_waddr_regs  out  6  byte address
- o_acl_item_din_regs  out  8  byte data
- o_acl_item_we_regs  out  1  byte write enable
- o_acl_item_rslt_regs  out  16  item result
- o_acl_item_complete_regs  out  1  configuration-complete pulse

## Operation
- Staging buffer: 64×8 flops, written only while o_host_cmd_rdy=1. Writes in any other state are dropped.
- Command accept: i_host_cmd_vld & o_host_cmd_rdy on a clock edge.
  - port_sel, item_sel, len and rslt are latched at accept.
  - The latched values drive the o_acl_* port_sel, item_sel and rslt outputs, held stable until DONE.
- Argument check at accept:
  - Opcode 11 → DONE with err=2.
  - WRITE with len=0, len>64 or port_sel=0 → DONE with err=1; no ACL strobes are issued.
  - COMMIT or CLEAR with port_sel=0 → DONE with err=1.
- States and transitions:
  - IDLE → WAIT_RDY on a valid accept; IDLE → DONE on a rejected accept.
  - WAIT_RDY → WRITE, COMMIT or CLEAR according to the opcode, once i_acl_list_rdy_regs is sampled 1.
  - WRITE: we=1 for exactly len consecutive cycles. waddr steps 0,1,…,len-1 and din=buf[waddr]. Then → DONE.
  - COMMIT: complete=1 for one cycle → DONE.
  - CLEAR: clr=1 for one cycle → CLR_WAIT.
  - CLR_WAIT: ignores rdy for 2 cycles, then waits for rdy=1 → DONE.
  - DONE: o_host_done=1 for one cycle with o_host_err → IDLE.
- WRITE does not assert complete; the host issues COMMIT after the last WRITE for a port.
- If rdy drops during WRITE, the byte stream is not paused; rdy is sampled only in WAIT_RDY and CLR_WAIT.

## Timing
- All outputs are registered. Reset value is 0 for every output, including o_host_cmd_rdy; o_host_cmd_rdy rises on the first edge after reset release.
- Accept at edge E0, rdy already high: first we/complete/clr is high in cycle E0+2.
  - WRITE: done is high in the cycle after the last we; accept-to-done = len+2 cycles.
  - COMMIT: accept-to-done = 3 cycles.
- Rejected command: done/err are high in cycle E0+1, and o_host_cmd_rdy is high again at E0+2.
- Back-to-back commands: the minimum command spacing is one IDLE cycle after done.
- Reset asserted mid-operation: all strobes drop asynchronously and the FSM returns to IDLE. The partial item is not committed, and the buffer contents are undefined.

## Configuration
- ACL_CFG_TIMEOUT_EN defined: a counter runs in WAIT_RDY and CLR_WAIT.
  - When RDY_TIMEOUT cycles elapse without rdy=1 → DONE with err=3, and no further ACL strobes are issued.
  - The counter clears on every state entry.
- ACL_CFG_TIMEOUT_EN not defined: no counter; the FSM waits for rdy indefinitely and err=3 is never produced.

## Test plan
- Load bytes 0xA0..0xA3, WRITE port_sel=0001, item=5, len=4, rslt=0x0203, rdy=1 → we high 4 cycles, waddr 0..3, din A0..A3, rslt=0x0203 stable; done with err=0 at accept+6.
- WRITE len=64 followed by COMMIT → 64 contiguous we cycles with waddr wrapping to 63 exactly, then a single complete pulse; two done pulses, both err=0.
- CLEAR with rdy forced low for 10 cycles after clr → clr is a one-cycle pulse; done occurs only after rdy returns high.
- WRITE len=0, len=65 and opcode 11 → no ACL strobes; done at accept+1 with err=1, 1 and 2 respectively.
- With ACL_CFG_TIMEOUT_EN and RDY_TIMEOUT=16, rdy held low → done with err=3 after 16 WAIT_RDY cycles; without the macro, no done after 1000 cycles.
- Assert i_rst in the middle of a WRITE of len 32 → we drops immediately, all outputs are 0, and o_host_cmd_rdy returns high one edge after release.
